// File: rtl/tone_burst_if.sv
// Configuration and status bundle between the register bank and the tone burst sequencer.
// Master side owns enable/trigger/config; slave side returns the waveform and status word.
interface tone_burst_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  enable;
    logic                  trigger;
    logic [DATA_WIDTH-1:0] pulse_count;
    logic [DATA_WIDTH-1:0] burst_count;
    logic [DATA_WIDTH-1:0] duty_cycle;
    logic [DATA_WIDTH-1:0] inter_burst_delay;
    logic [DATA_WIDTH-1:0] pulse_period;
    logic                  pulse_out;
    logic                  burst_active;
    logic                  done;
    logic [DATA_WIDTH-1:0] status_out;

    modport master (
        output enable, trigger, pulse_count, burst_count, duty_cycle,
               inter_burst_delay, pulse_period,
        input  pulse_out, burst_active, done, status_out
    );

    modport slave (
        input  enable, trigger, pulse_count, burst_count, duty_cycle,
               inter_burst_delay, pulse_period,
        output pulse_out, burst_active, done, status_out
    );
endinterface

// File: rtl/tone_burst_sequencer.sv
// Burst sequencer: IDLE -> BURST (N pulses of P cycles, H high) -> DELAY (D cycles), repeated B times.
// Outputs valid one cycle after a start; no backpressure, enable low aborts on the next edge.
module tone_burst_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int DUTY_SHIFT = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    tone_burst_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BURST = 2'd1;
    localparam logic [1:0] S_DELAY = 2'd2;

    localparam logic [DATA_WIDTH-1:0] DUTY_FULL = DATA_WIDTH'(64'd1 << DUTY_SHIFT);
    localparam logic [DATA_WIDTH-1:0] ONE       = DATA_WIDTH'(1);

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] n_q, n_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH-1:0] d_q, d_d;
    logic [DATA_WIDTH-1:0] p_q, p_d;
    logic [DATA_WIDTH-1:0] high_q, high_d;
    logic [DATA_WIDTH-1:0] period_cnt_q, period_cnt_d;
    logic [DATA_WIDTH-1:0] pulse_idx_q, pulse_idx_d;
    logic [DATA_WIDTH-1:0] burst_idx_q, burst_idx_d;
    logic [DATA_WIDTH-1:0] delay_cnt_q, delay_cnt_d;
    logic                  pulse_out_q, pulse_out_d;
    logic                  done_q, done_d;
    logic                  done_flag_q, done_flag_d;
    logic                  abort_flag_q, abort_flag_d;
    logic                  cfg_error_q, cfg_error_d;

    logic [DATA_WIDTH-1:0] duty_clamped;
    logic [DATA_WIDTH-1:0] high_calc;
    logic                  cfg_bad;
    logic                  last_period;
    logic                  last_pulse;
    logic                  last_burst;
    logic                  last_delay;

    // High time uses a double-width product so P * 1024 cannot overflow.
    always_comb begin
        duty_clamped = (bus.duty_cycle > DUTY_FULL) ? DUTY_FULL : bus.duty_cycle;
        high_calc    = DATA_WIDTH'(({{DATA_WIDTH{1'b0}}, bus.pulse_period} *
                                    {{DATA_WIDTH{1'b0}}, duty_clamped}) >> DUTY_SHIFT);
        cfg_bad      = (bus.pulse_count == '0) || (bus.burst_count == '0) ||
                       (bus.pulse_period == '0);
        last_period  = (period_cnt_q == p_q - ONE);
        last_pulse   = (pulse_idx_q == n_q - ONE);
        last_burst   = (burst_idx_q + ONE == b_q);
        last_delay   = (delay_cnt_q == d_q - ONE);
    end

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        b_d          = b_q;
        d_d          = d_q;
        p_d          = p_q;
        high_d       = high_q;
        period_cnt_d = period_cnt_q;
        pulse_idx_d  = pulse_idx_q;
        burst_idx_d  = burst_idx_q;
        delay_cnt_d  = delay_cnt_q;
        done_d       = 1'b0;
        done_flag_d  = done_flag_q;
        abort_flag_d = abort_flag_q;
        cfg_error_d  = cfg_error_q;

        case (state_q)
            S_IDLE: begin
                if (bus.trigger && bus.enable) begin
                    if (cfg_bad) begin
                        cfg_error_d = 1'b1;
                    end else begin
                        n_d          = bus.pulse_count;
                        b_d          = bus.burst_count;
                        d_d          = bus.inter_burst_delay;
                        p_d          = bus.pulse_period;
                        high_d       = high_calc;
                        period_cnt_d = '0;
                        pulse_idx_d  = '0;
                        burst_idx_d  = '0;
                        delay_cnt_d  = '0;
                        done_flag_d  = 1'b0;
                        abort_flag_d = 1'b0;
                        cfg_error_d  = 1'b0;
                        state_d      = S_BURST;
                    end
                end
            end
            S_BURST: begin
                // Abort is checked first so it overrides a coincident run completion.
                if (!bus.enable) begin
                    abort_flag_d = 1'b1;
                    state_d      = S_IDLE;
                end else if (last_period) begin
                    period_cnt_d = '0;
                    if (last_pulse) begin
                        pulse_idx_d = '0;
                        burst_idx_d = burst_idx_q + ONE;
                        if (last_burst) begin
                            done_d      = 1'b1;
                            done_flag_d = 1'b1;
                            state_d     = S_IDLE;
                        end else if (d_q != '0) begin
                            delay_cnt_d = '0;
                            state_d     = S_DELAY;
                        end
                    end else begin
                        pulse_idx_d = pulse_idx_q + ONE;
                    end
                end else begin
                    period_cnt_d = period_cnt_q + ONE;
                end
            end
            S_DELAY: begin
                if (!bus.enable) begin
                    abort_flag_d = 1'b1;
                    state_d      = S_IDLE;
                end else if (last_delay) begin
                    delay_cnt_d  = '0;
                    period_cnt_d = '0;
                    pulse_idx_d  = '0;
                    state_d      = S_BURST;
                end else begin
                    delay_cnt_d = delay_cnt_q + ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        pulse_out_d = (state_d == S_BURST) && (period_cnt_d < high_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            n_q          <= '0;
            b_q          <= '0;
            d_q          <= '0;
            p_q          <= '0;
            high_q       <= '0;
            period_cnt_q <= '0;
            pulse_idx_q  <= '0;
            burst_idx_q  <= '0;
            delay_cnt_q  <= '0;
            pulse_out_q  <= 1'b0;
            done_q       <= 1'b0;
            done_flag_q  <= 1'b0;
            abort_flag_q <= 1'b0;
            cfg_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            b_q          <= b_d;
            d_q          <= d_d;
            p_q          <= p_d;
            high_q       <= high_d;
            period_cnt_q <= period_cnt_d;
            pulse_idx_q  <= pulse_idx_d;
            burst_idx_q  <= burst_idx_d;
            delay_cnt_q  <= delay_cnt_d;
            pulse_out_q  <= pulse_out_d;
            done_q       <= done_d;
            done_flag_q  <= done_flag_d;
            abort_flag_q <= abort_flag_d;
            cfg_error_q  <= cfg_error_d;
        end
    end

    assign bus.pulse_out    = pulse_out_q;
    assign bus.burst_active = (state_q == S_BURST);
    assign bus.done         = done_q;
    assign bus.status_out   = {burst_idx_q[DATA_WIDTH-9:0], 3'b000, cfg_error_q, abort_flag_q,
                               done_flag_q, (state_q == S_DELAY), (state_q != S_IDLE)};
endmodule
